// File: rtl/gate_table_sequencer_if.sv
// Handshake and gate-drive bundle for gate_table_sequencer.
// The master side issues start/abort and returns the gate output; the slave is the sequencer.
interface gate_table_sequencer_if #(
  parameter int unsigned N_IN = 2
) ();
  localparam int unsigned M = 1 << N_IN;

  logic            start;
  logic            abort;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN-1:0] fail_minterm;
  logic [M-1:0]    result_vec;

  modport master (
    output start, abort, dut_out,
    input  dut_in, busy, done, pass, fail_minterm, result_vec
  );

  modport slave (
    input  start, abort, dut_out,
    output dut_in, busy, done, pass, fail_minterm, result_vec
  );
endinterface

// File: rtl/gate_table_sequencer.sv
// Steps a combinational gate through every minterm and compares its output with EXPECT.
// Define GATE_SEQ_STOP_ON_FAIL_EN to end the sweep at the first mismatching minterm.
module gate_table_sequencer #(
  parameter int unsigned              N_IN   = 2,
  parameter logic [(1 << N_IN)-1:0]   EXPECT = 4'b1000,
  parameter int unsigned              SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_table_sequencer_if.slave   seq_if
);

  localparam int unsigned M = 1 << N_IN;

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  state_e          state_q;
  logic [N_IN:0]   m_q;
  logic [3:0]      wait_cnt_q;
  logic [N_IN-1:0] dut_in_q;
  logic [N_IN-1:0] fail_minterm_q;
  logic [M-1:0]    result_vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic [N_IN-1:0] m_idx;
  logic            mismatch;
  logic            last;
  logic            finish;

  assign m_idx    = m_q[N_IN-1:0];
  assign mismatch = (seq_if.dut_out != EXPECT[m_idx]);
  // m_q is one bit wider than a minterm index, so the last minterm is matched explicitly.
  assign last     = (m_q == (N_IN+1)'(M - 1));

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign finish = last || mismatch;
`else
  assign finish = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      m_q            <= '0;
      wait_cnt_q     <= '0;
      dut_in_q       <= '0;
      fail_minterm_q <= '0;
      result_vec_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (seq_if.start) begin
            state_q        <= StWait;
            busy_q         <= 1'b1;
            m_q            <= '0;
            dut_in_q       <= '0;
            wait_cnt_q     <= '0;
            result_vec_q   <= '0;
            pass_q         <= 1'b1;
            fail_minterm_q <= '0;
          end
        end
        StWait: begin
          if (seq_if.abort) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            dut_in_q   <= '0;
            pass_q     <= 1'b0;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
            if (wait_cnt_q == 4'(SETTLE - 1)) begin
              state_q <= StSample;
            end
          end
        end
        StSample: begin
          if (seq_if.abort) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            dut_in_q   <= '0;
            pass_q     <= 1'b0;
            wait_cnt_q <= '0;
          end else begin
            result_vec_q[m_idx] <= seq_if.dut_out;
            if (mismatch && pass_q) begin
              pass_q         <= 1'b0;
              fail_minterm_q <= m_idx;
            end
            if (finish) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StWait;
              m_q        <= m_q + (N_IN+1)'(1);
              dut_in_q   <= m_idx + N_IN'(1);
              wait_cnt_q <= '0;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          dut_in_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign seq_if.dut_in       = dut_in_q;
  assign seq_if.busy         = busy_q;
  assign seq_if.done         = done_q;
  assign seq_if.pass         = pass_q;
  assign seq_if.fail_minterm = fail_minterm_q;
  assign seq_if.result_vec   = result_vec_q;

endmodule

// File: tb/tb_gate_table_sequencer.sv
// Randomised bench for gate_table_sequencer: two instances (2-input/SETTLE=1 and
// 3-input/SETTLE=2) driven by table-lookup gate models and compared to a sweep model.
module tb_gate_table_sequencer;

  localparam int unsigned    S_A   = 1;
  localparam logic [3:0]     EXP_A = 4'b1000;
  localparam int unsigned    S_B   = 2;
  localparam logic [7:0]     EXP_B = 8'h80;

  logic       clk;
  logic       rst_n;
  logic [3:0] tbl_a;
  logic [7:0] tbl_b;

  int n_total;
  int n_bad;

  gate_table_sequencer_if #(.N_IN(2)) bus_a ();
  gate_table_sequencer_if #(.N_IN(3)) bus_b ();

  assign bus_a.dut_out = tbl_a[bus_a.dut_in];
  assign bus_b.dut_out = tbl_b[bus_b.dut_in];

  gate_table_sequencer #(.N_IN(2), .EXPECT(EXP_A), .SETTLE(S_A)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus_a)
  );

  gate_table_sequencer #(.N_IN(3), .EXPECT(EXP_B), .SETTLE(S_B)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of one full run: which minterms get swept, the recorded table,
  // the verdict and the edge count from start to the done cycle.
  task automatic model(input int m_cnt, input int s, input logic [7:0] tbl,
                       input logic [7:0] expv, output int last_m, output int lat,
                       output logic [7:0] res, output bit ok, output int fail);
    ok     = 1'b1;
    fail   = 0;
    last_m = m_cnt - 1;
    for (int k = 0; k < m_cnt; k++) begin
      if (ok && (tbl[k] !== expv[k])) begin
        ok   = 1'b0;
        fail = k;
      end
    end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    if (!ok) last_m = fail;
`endif
    res = '0;
    for (int k = 0; k <= last_m; k++) res[k] = tbl[k];
    lat = (last_m + 1) * (s + 1);
  endtask

  task automatic run_a(input logic [3:0] tbl, input bit hold_start, input bit do_abort,
                       input bit abort_with_start);
    int         last_m, lat, fail, abort_at, n_smp, exp_in;
    logic [7:0] res, part;
    bit         ok;
    model(4, S_A, {4'b0, tbl}, {4'b0, EXP_A}, last_m, lat, res, ok, fail);
    abort_at    = do_abort ? int'($urandom_range(0, lat - 1)) : -1;
    tbl_a       = tbl;
    bus_a.start = 1'b1;
    bus_a.abort = abort_with_start;
    step();
    bus_a.abort = 1'b0;
    if (!hold_start) bus_a.start = 1'b0;
    for (int j = 0; j <= lat; j++) begin
      if (j == abort_at) begin
        bus_a.abort = 1'b1;
        bus_a.start = 1'b0;
        step();
        bus_a.abort = 1'b0;
        n_smp = j / (S_A + 1);
        part  = '0;
        for (int k = 0; k < n_smp; k++) part[k] = res[k];
        check_eq("abort_busy", 32'(bus_a.busy), 32'd0);
        check_eq("abort_dut_in", 32'(bus_a.dut_in), 32'd0);
        check_eq("abort_pass", 32'(bus_a.pass), 32'd0);
        check_eq("abort_done", 32'(bus_a.done), 32'd0);
        check_eq("abort_result", 32'(bus_a.result_vec), 32'(part[3:0]));
        for (int k = 0; k < 4; k++) begin
          step();
          check_eq("abort_no_done", 32'(bus_a.done), 32'd0);
        end
        return;
      end
      exp_in = j / (S_A + 1);
      if (exp_in > last_m) exp_in = last_m;
      check_eq("dut_in", 32'(bus_a.dut_in), 32'(exp_in));
      check_eq("busy", 32'(bus_a.busy), 32'(j < lat));
      check_eq("done", 32'(bus_a.done), 32'(j == lat));
      if (j == lat) begin
        check_eq("pass", 32'(bus_a.pass), 32'(ok));
        check_eq("fail_minterm", 32'(bus_a.fail_minterm), 32'(fail));
        check_eq("result_vec", 32'(bus_a.result_vec), 32'(res[3:0]));
        bus_a.start = 1'b0;
      end
      step();
    end
    check_eq("idle_done", 32'(bus_a.done), 32'd0);
    check_eq("idle_dut_in", 32'(bus_a.dut_in), 32'd0);
    check_eq("idle_busy", 32'(bus_a.busy), 32'd0);
    check_eq("idle_pass_held", 32'(bus_a.pass), 32'(ok));
  endtask

  task automatic run_b(input logic [7:0] tbl, input bit hold_start);
    int         last_m, lat, fail, exp_in;
    logic [7:0] res;
    bit         ok;
    model(8, S_B, tbl, EXP_B, last_m, lat, res, ok, fail);
    tbl_b       = tbl;
    bus_b.start = 1'b1;
    step();
    if (!hold_start) bus_b.start = 1'b0;
    for (int j = 0; j <= lat; j++) begin
      exp_in = j / (S_B + 1);
      if (exp_in > last_m) exp_in = last_m;
      check_eq("b_dut_in", 32'(bus_b.dut_in), 32'(exp_in));
      check_eq("b_done", 32'(bus_b.done), 32'(j == lat));
      if (j == lat) begin
        check_eq("b_pass", 32'(bus_b.pass), 32'(ok));
        check_eq("b_fail_minterm", 32'(bus_b.fail_minterm), 32'(fail));
        check_eq("b_result_vec", 32'(bus_b.result_vec), 32'(res));
        bus_b.start = 1'b0;
      end
      step();
    end
    check_eq("b_idle_done", 32'(bus_b.done), 32'd0);
    check_eq("b_idle_dut_in", 32'(bus_b.dut_in), 32'd0);
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus_a.done), 32'd0);
    check_eq({tag, "_pass"}, 32'(bus_a.pass), 32'd0);
    check_eq({tag, "_dut_in"}, 32'(bus_a.dut_in), 32'd0);
    check_eq({tag, "_fail"}, 32'(bus_a.fail_minterm), 32'd0);
    check_eq({tag, "_result"}, 32'(bus_a.result_vec), 32'd0);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    tbl_a       = 4'b1000;
    tbl_b       = 8'h80;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;
    repeat (3) step();
    check_reset_a("rst");
    check_eq("rst_b_result", 32'(bus_b.result_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed: AND gate, output stuck low, output stuck high.
    run_a(4'b1000, 1'b0, 1'b0, 1'b0);
    run_a(4'b0000, 1'b0, 1'b0, 1'b0);
    run_a(4'b1111, 1'b0, 1'b0, 1'b0);
    // start held high through the run, and start together with abort in idle.
    run_a(4'b1000, 1'b1, 1'b0, 1'b0);
    run_a(4'b1000, 1'b0, 1'b0, 1'b1);

    // Abort while minterm 2 is being settled.
    tbl_a       = 4'b1000;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    while (bus_a.dut_in != 2'd2) step();
    bus_a.abort = 1'b1;
    step();
    bus_a.abort = 1'b0;
    check_eq("abort2_busy", 32'(bus_a.busy), 32'd0);
    check_eq("abort2_dut_in", 32'(bus_a.dut_in), 32'd0);
    check_eq("abort2_pass", 32'(bus_a.pass), 32'd0);
    check_eq("abort2_result", 32'(bus_a.result_vec), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("abort2_no_done", 32'(bus_a.done), 32'd0);
    end

    // Asynchronous reset while minterm 1 is applied.
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    repeat (2) step();
    check_eq("pre_rst_dut_in", 32'(bus_a.dut_in), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_a("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_a(4'b1000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_a(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end

    run_b(8'h80, 1'b1);
    for (int i = 0; i < 3; i++) run_b(8'($urandom_range(0, 255)), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_table_sequencer.md
Name: gate_table_sequencer

Overview:
- Sequences a combinational gate block through every input minterm, in order, and checks its output against an expected truth table.
- Drives the gate inputs, waits a settle interval, samples the gate output and records the observed table.
- Reports pass/fail and the first failing minterm with a start/busy/done handshake.
- Sits beside any small gate module as its self-test/characterisation controller.

Parameters:
- N_IN, 2, number of gate inputs (1..4); minterm count M = 2**N_IN.
- EXPECT, 4'b1000, expected truth table, width M; bit m = expected output for input value m.
- SETTLE, 1, cycles the inputs are held before sampling (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; honoured only in IDLE.
- abort  input  1  cancel a run; honoured only when busy.
- dut_out  input  1  output of the gate under control.
- dut_in  output  N_IN  input vector applied to the gate (minterm index).
- busy  output  1  high in WAIT and SAMPLE.
- done  output  1  one-cycle pulse at end of a completed run.
- pass  output  1  1 = every sampled minterm matched EXPECT; valid from done until the next start.
- fail_minterm  output  N_IN  lowest mismatching minterm; 0 if pass.
- result_vec  output  M  observed truth table; bit m = dut_out sampled for minterm m.

Behaviour:
- Reset (async, rst_n=0): state IDLE, dut_in=0, busy=0, done=0, pass=0, fail_minterm=0, result_vec=0, internal counters=0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: on start=1 at an edge:
  - go to WAIT with m=0, dut_in=0, wait_cnt=0;
  - clear result_vec, set pass=1, fail_minterm=0.
- WAIT: wait_cnt increments each cycle; after SETTLE cycles in WAIT go to SAMPLE.
- SAMPLE (1 cycle): at the closing edge:
  - result_vec[m] <= dut_out;
  - if dut_out != EXPECT[m] and pass is still 1: pass <= 0, fail_minterm <= m;
  - if m == M-1: go to DONE; else m <= m+1, dut_in <= m+1, wait_cnt <= 0, go to WAIT.
- DONE (1 cycle): done=1, then IDLE. dut_in returns to 0 on entry to IDLE.
- Latency: done is high in the cycle starting M*(SETTLE+1) edges after the start edge. Example: N_IN=2, SETTLE=1 gives 8.
- dut_in changes only on WAIT entry, so it is stable for SETTLE+1 cycles per minterm.
- m counter is N_IN+1 bits wide, so there is no wrap at M-1 and the last minterm is compared explicitly.
- start while busy or in DONE: ignored.
- abort=1 in WAIT/SAMPLE: next state IDLE, dut_in=0, no done pulse, pass=0. result_vec keeps the partially filled bits.
- abort and start together in IDLE: start wins, because abort is ignored when not busy.
- Reset mid-run: immediate return to reset values.

Optional Feature:
- Macro GATE_SEQ_STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE goes directly to DONE after recording result_vec[m], pass=0 and fail_minterm=m. Later result_vec bits stay 0 and done pulses early.
- Undefined: all M minterms are always swept. pass and fail_minterm are as above.

Test Plan:
- AND gate model (dut_out=&dut_in), defaults, start pulse:
  - dut_in steps 0,1,2,3, each held 2 cycles;
  - done 8 cycles after start; pass=1, result_vec=4'b1000, fail_minterm=0.
- dut_out tied 0, defaults: done at +8, pass=0, fail_minterm=3, result_vec=4'b0000.
- dut_out tied 1, defaults:
  - without the macro: done at +8, pass=0, fail_minterm=0, result_vec=4'b1111;
  - with GATE_SEQ_STOP_ON_FAIL_EN: done at +2, result_vec=4'b0001.
- AND model, abort during minterm 2:
  - no done pulse; busy falls next cycle; dut_in=0, pass=0;
  - result_vec=4'b0000 (bits 0,1 sampled as 0).
- rst_n low mid-run (minterm 1), release, start again: all outputs reset immediately, and the second run completes normally with pass=1.
- start re-asserted every cycle during a run: no restart; single done at +8. N_IN=3, SETTLE=2, EXPECT=8'h80 with a 3-input AND gives done at +24, pass=1.
